// File: rtl/calc_pkg.sv
// calc_pkg: opcodes, FSM state type and width helper shared by the calculator front-end.
package calc_pkg;
  localparam logic [2:0] OP_ADD_AB = 3'b000;
  localparam logic [2:0] OP_SUB_AB = 3'b001;
  localparam logic [2:0] OP_ABS_B  = 3'b010;
  localparam logic [2:0] OP_ADD_BA = 3'b100;
  localparam logic [2:0] OP_SUB_BA = 3'b101;
  localparam logic [2:0] OP_ABS_A  = 3'b110;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  function automatic logic [63:0] most_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction
endpackage

// File: rtl/calc_seq_if.sv
// calc_seq_if: command/response channels plus accumulator status of the calculator front-end.
interface calc_seq_if #(parameter int W = 16);
  logic cmd_valid, cmd_ready, cmd_load;
  logic [2:0] cmd_op;
  logic [W-1:0] cmd_data;
  logic rsp_valid, rsp_ready, rsp_ovf, ovf_sticky;
  logic [W-1:0] rsp_data, acc;
  modport master(output cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready,
                 input cmd_ready, rsp_valid, rsp_data, rsp_ovf, ovf_sticky, acc);
  modport slave(input cmd_valid, cmd_load, cmd_op, cmd_data, rsp_ready,
                output cmd_ready, rsp_valid, rsp_data, rsp_ovf, ovf_sticky, acc);
endinterface

// File: rtl/calc_exec.sv
// calc_exec: combinational signed add/sub/abs built around one adder with carry-in.
module calc_exec #(parameter int W = 16) (
  input  logic [2:0]   i_op,
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_r,
  output logic         o_ovf
);
  logic [W-1:0] w_p, w_q, w_x, w_y;
  logic w_neg;
  // op[2] swaps operands; abs negates q through the same adder as 0 + ~q + 1
  always_comb begin
    w_p = i_op[2] ? i_b : i_a;
    w_q = i_op[2] ? i_a : i_b;
    w_neg = i_op[1] ? w_q[W-1] : i_op[0];
    w_x = i_op[1] ? '0 : w_p;
    w_y = w_neg ? ~w_q : w_q;
    o_r = w_x + w_y + W'(w_neg);
    o_ovf = (w_x[W-1] == w_y[W-1]) && (o_r[W-1] != w_x[W-1]);
  end
endmodule

// File: rtl/calc_seq.sv
// calc_seq: flow-controlled accumulator front-end around calc_exec.
module calc_seq import calc_pkg::*; #(parameter int W = 16) (
  input logic clk,
  input logic rst_n,
  calc_seq_if.slave bus
);
  state_t r_state, w_next;
  logic r_load, r_rsp_ovf, r_sticky, w_ovf;
  logic [2:0] r_op;
  logic [W-1:0] r_data, r_acc, r_rsp_data, w_r;
  calc_exec #(.W(W)) u_exec (.i_op(r_op), .i_a(r_acc), .i_b(r_data), .o_r(w_r), .o_ovf(w_ovf));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = bus.cmd_valid ? EXEC : IDLE;
    else if (r_state == EXEC) w_next = RESP;
    else if (r_state == RESP) w_next = bus.rsp_ready ? IDLE : RESP;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_load <= 1'b0;
      r_op <= '0;
      r_data <= '0;
      r_acc <= '0;
      r_rsp_data <= '0;
      r_rsp_ovf <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      if (r_state == IDLE && bus.cmd_valid) begin
        r_load <= bus.cmd_load;
        r_op <= bus.cmd_op;
        r_data <= bus.cmd_data;
      end
      if (r_state == EXEC) begin
        r_acc <= r_load ? r_data : w_r;
        r_rsp_data <= r_load ? r_data : w_r;
        r_rsp_ovf <= !r_load && w_ovf;
        r_sticky <= !r_load && (r_sticky || w_ovf);
      end
    end
  assign bus.cmd_ready = r_state == IDLE;
  assign bus.rsp_valid = r_state == RESP;
  assign bus.rsp_data = r_rsp_data;
  assign bus.rsp_ovf = r_rsp_ovf;
  assign bus.ovf_sticky = r_sticky;
  assign bus.acc = r_acc;
endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: directed scoreboard bench for calc_seq with an integer-range reference model.
module tb_calc_seq;
  import calc_pkg::*;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0, errors = 0;
  logic [15:0] m_acc;
  logic m_st;
  typedef struct packed {logic [15:0] d; logic o; logic s;} exp_t;
  exp_t q[$];
  exp_t e;
  calc_seq_if #(.W(16)) bus();
  calc_seq #(.W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic push(input logic ld, input logic [2:0] op, input logic [15:0] b);
    int sa, sb, full;
    logic o;
    sa = int'($signed(m_acc));
    sb = int'($signed(b));
    case (op)
      OP_ADD_AB, OP_ADD_BA: full = sa + sb;
      OP_SUB_AB: full = sa - sb;
      OP_SUB_BA: full = sb - sa;
      OP_ABS_B, 3'b011: full = sb < 0 ? -sb : sb;
      default: full = sa < 0 ? -sa : sa;
    endcase
    if (ld) full = sb;
    o = !ld && (full > 32767 || full < -32768);
    m_acc = full[15:0];
    m_st = !ld && (m_st || o);
    q.push_back('{d: m_acc, o: o, s: m_st});
  endtask
  task automatic issue(input logic ld, input logic [2:0] op, input logic [15:0] b);
    push(ld, op, b);
    bus.cmd_valid = 1'b1;
    bus.cmd_load = ld;
    bus.cmd_op = op;
    bus.cmd_data = b;
    for (int i = 0; i < 50 && bus.cmd_ready !== 1'b1; i++) @(negedge clk);
    chk("accept", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask
  task automatic check_rsp(input string tag);
    chk({tag, "_qsize"}, 32'(q.size() > 0), 32'd1);
    e = q.size() > 0 ? q.pop_front() : '0;
    chk({tag, "_data"}, 32'(bus.rsp_data), 32'(e.d));
    chk({tag, "_ovf"}, 32'(bus.rsp_ovf), 32'(e.o));
    chk({tag, "_acc"}, 32'(bus.acc), 32'(e.d));
    chk({tag, "_sticky"}, 32'(bus.ovf_sticky), 32'(e.s));
  endtask
  task automatic expect_rsp(input string tag);
    @(negedge clk);
    chk({tag, "_exec_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_exec_ready"}, 32'(bus.cmd_ready), 32'd0);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check_rsp(tag);
    @(negedge clk);
    chk({tag, "_ready_again"}, 32'(bus.cmd_ready), 32'd1);
  endtask
  task automatic cmd(input string tag, input logic ld, input logic [2:0] op, input logic [15:0] b);
    issue(ld, op, b);
    expect_rsp(tag);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
    chk({tag, "_acc"}, 32'(bus.acc), 32'd0);
    chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_rsp_ovf"}, 32'(bus.rsp_ovf), 32'd0);
    chk({tag, "_sticky"}, 32'(bus.ovf_sticky), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_data = '0;
    bus.rsp_ready = 1'b1;
    m_acc = '0;
    m_st = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    cmd("load5", 1'b1, OP_ADD_AB, 16'h0005);
    cmd("add3", 1'b0, OP_ADD_AB, 16'h0003);
    cmd("load7fff", 1'b1, OP_ADD_AB, 16'h7FFF);
    cmd("add_ovf", 1'b0, OP_ADD_AB, 16'h0001);
    cmd("load0", 1'b1, OP_ADD_AB, 16'h0000);
    cmd("load3", 1'b1, OP_ADD_AB, 16'h0003);
    cmd("sub_ba", 1'b0, OP_SUB_BA, 16'h0001);
    cmd("abs_a", 1'b0, 3'b111, 16'h1234);
    cmd("load8000", 1'b1, OP_ADD_AB, 16'(most_neg(16)));
    cmd("abs_min", 1'b0, OP_ABS_A, 16'h0000);
    cmd("abs_b", 1'b0, 3'b011, 16'hFFF6);
    cmd("add_ba", 1'b0, OP_ADD_BA, 16'h0005);
    cmd("load8000b", 1'b1, OP_ADD_AB, 16'h8000);
    cmd("sub_ovf", 1'b0, OP_SUB_AB, 16'h0001);
    cmd("sub_ba_ovf", 1'b0, OP_SUB_BA, 16'hFFFE);
    cmd("abs_b_pos", 1'b0, OP_ABS_B, 16'h0042);
    bus.rsp_ready = 1'b0;
    issue(1'b1, OP_ADD_AB, 16'h0010);
    @(negedge clk);
    @(negedge clk);
    push(1'b0, OP_ADD_AB, 16'h0001);
    bus.cmd_valid = 1'b1;
    bus.cmd_load = 1'b0;
    bus.cmd_op = OP_ADD_AB;
    bus.cmd_data = 16'h0001;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_data", 32'(bus.rsp_data), 32'h0010);
      chk("hold_ready", 32'(bus.cmd_ready), 32'd0);
    end
    check_rsp("hold");
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("hold_release_ready", 32'(bus.cmd_ready), 32'd1);
    chk("hold_release_valid", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
    expect_rsp("second");
    issue(1'b0, OP_ADD_AB, 16'h0005);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset("rst_exec");
    q.delete();
    m_acc = '0;
    m_st = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_acc", 32'(bus.acc), 32'd0);
    chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
    cmd("post_rst_add", 1'b0, OP_ADD_AB, 16'h0004);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
